// File: rtl/arbitro_sumador_pkg.sv
// Shared definitions for the round-robin adder arbiter: state encoding,
// default sizes and the pointer increment helper.
package arbitro_sumador_pkg;

  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned DATA_W_DEF  = 32;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  // Next round-robin index, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/arbitro_sumador_pick.sv
// Combinational round-robin priority search: the first set request at or
// after ptr (wrapping) wins when en is high.
module arb_rr_pick
  import arbitro_sumador_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  logic [NUM_REQ-1:0] rot;
  logic [NUM_REQ-1:0] sh;

  // Rotate so ptr lands on bit 0, then take the lowest set offset.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    sh    = '0;
    rot   = NUM_REQ'({req, req} >> ptr);
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      sh = rot >> i;
      if (en && !any && sh[0]) begin
        idx = ID_W'((32'(ptr) + i) % NUM_REQ);
        any = 1'b1;
      end
    end
    if (any) grant = NUM_REQ'(1) << idx;
  end

endmodule

// File: rtl/arbitro_sumador.sv
// Shared adder with round-robin requester arbitration and a registered,
// back-pressurable response. SUMADOR_ARB_CARRY_EN adds the resp_carry port.
module arbitro_sumador
  import arbitro_sumador_pkg::*;
#(
  parameter  int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter  int unsigned DATA_W  = DATA_W_DEF,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      resp_valid,
  output logic [ID_W-1:0]           resp_id,
  output logic [DATA_W-1:0]         resp_result,
  input  logic                      resp_ready,
  output logic                      busy
`ifdef SUMADOR_ARB_CARRY_EN
  ,
  output logic                      resp_carry
`endif
);

  logic [0:0]         state;
  logic [0:0]         state_nxt;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    win;
  logic [NUM_REQ-1:0] grant;
  logic               any;
  logic               can_accept;
  logic [DATA_W-1:0]  a_sel;
  logic [DATA_W-1:0]  b_sel;

  assign can_accept = !resp_valid || resp_ready;

  // rst_n gates the enable so nothing is granted while reset is held.
  arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr),
    .en    (can_accept && rst_n),
    .grant (grant),
    .idx   (win),
    .any   (any)
  );

  assign req_ready = grant;

  assign a_sel = DATA_W'(req_a >> (32'(win) * DATA_W));
  assign b_sel = DATA_W'(req_b >> (32'(win) * DATA_W));

`ifdef SUMADOR_ARB_CARRY_EN
  logic [DATA_W:0] sum;
  assign sum = {1'b0, a_sel} + {1'b0, b_sel};
`else
  logic [DATA_W-1:0] sum;
  assign sum = a_sel + b_sel;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  // A grant always fills the register; it drains only on an ungranted consume.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (any) state_nxt = ST_FULL;
      ST_FULL:  if (!any && resp_ready) state_nxt = ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  assign resp_valid = (state == ST_FULL);
  assign busy       = resp_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= '0;
      resp_id     <= '0;
      resp_result <= '0;
`ifdef SUMADOR_ARB_CARRY_EN
      resp_carry  <= 1'b0;
`endif
    end else if (any) begin
      ptr         <= ID_W'(rr_next(32'(win), NUM_REQ));
      resp_id     <= win;
      resp_result <= sum[DATA_W-1:0];
`ifdef SUMADOR_ARB_CARRY_EN
      resp_carry  <= sum[DATA_W];
`endif
    end
  end

endmodule

// File: tb/tb_arbitro_sumador.sv
// Scoreboard bench for arbitro_sumador: grants push expected results, a
// negedge monitor pops and compares on every consumed response.
module tb_arbitro_sumador;

  localparam int unsigned N = 4;
  localparam int unsigned W = 32;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] res;
    logic        carry;
  } exp_t;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic           resp_valid;
  logic [1:0]     resp_id;
  logic [W-1:0]   resp_result;
  logic           resp_ready;
  logic           busy;
  logic           resp_carry;

  logic [W-1:0] opa [N];
  logic [W-1:0] opb [N];
  exp_t         sb [$];
  int           n_checks = 0;
  int           n_pass   = 0;

  arbitro_sumador #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_id     (resp_id),
    .resp_result (resp_result),
    .resp_ready  (resp_ready),
    .busy        (busy)
`ifdef SUMADOR_ARB_CARRY_EN
    ,
    .resp_carry  (resp_carry)
`endif
  );

`ifndef SUMADOR_ARB_CARRY_EN
  assign resp_carry = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = opa[i];
      req_b[i*W +: W] = opb[i];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_grant(input int i);
    exp_t       e;
    logic [32:0] s;
    s       = {1'b0, opa[i]} + {1'b0, opb[i]};
    e.id    = 2'(i);
    e.res   = s[31:0];
`ifdef SUMADOR_ARB_CARRY_EN
    e.carry = s[32];
`else
    e.carry = 1'b0;
`endif
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a response is consumed at the next edge when valid and ready.
  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_resp", 64'(resp_id), 64'hdead);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_id", 64'(resp_id), 64'(e.id));
        check("sb_result", 64'(resp_result), 64'(e.res));
`ifdef SUMADOR_ARB_CARRY_EN
        check("sb_carry", 64'(resp_carry), 64'(e.carry));
`endif
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      opa[i] = 32'(32'h100 * (i + 1));
      opb[i] = 32'(i + 1);
    end
    rst_n      = 1'b0;
    req_valid  = 4'b1111;
    resp_ready = 1'b1;

    // Reset held with all requests pending
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'h0);
    check("rst_resp_valid", 64'(resp_valid), 64'h0);
    check("rst_resp_result", 64'(resp_result), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    step();
    rst_n = 1'b1;

    // Fairness: grants 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("rr_grant", 64'(req_ready), 64'(4'b0001 << (k % 4)));
      push_grant(k % 4);
      step();
    end
    req_valid = 4'b0000;
    step();

    // Single request on 1 (ptr now 1)
    opa[1] = 32'd5; opb[1] = 32'd7;
    req_valid = 4'b0010;
    @(negedge clk);
    check("single_grant", 64'(req_ready), 64'h2);
    push_grant(1);
    step();
    // Hold the result and post request 2 under backpressure
    req_valid  = 4'b0100;
    resp_ready = 1'b0;
    opa[2] = 32'h1000; opb[2] = 32'h0234;
    @(negedge clk);
    check("single_valid", 64'(resp_valid), 64'h1);
    check("single_id", 64'(resp_id), 64'h1);
    check("single_result", 64'(resp_result), 64'd12);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      check("bp_no_grant", 64'(req_ready), 64'h0);
      check("bp_hold_valid", 64'(resp_valid), 64'h1);
      check("bp_hold_result", 64'(resp_result), 64'd12);
      check("bp_hold_id", 64'(resp_id), 64'h1);
      step();
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_grant", 64'(req_ready), 64'h4);
    push_grant(2);
    step();
    req_valid = 4'b0000;
    @(negedge clk);
    check("bp_new_result", 64'(resp_result), 64'h1234);
    check("bp_new_id", 64'(resp_id), 64'h2);
    step();

    // Wrap-around sum on requester 3, then back-to-back sole requester
    opa[3] = 32'hFFFF_FFFF; opb[3] = 32'd1;
    req_valid = 4'b1000;
    @(negedge clk);
    check("wrap_grant", 64'(req_ready), 64'h8);
    push_grant(3);
    step();
    opa[3] = 32'd3; opb[3] = 32'd4;
    @(negedge clk);
    check("wrap_result", 64'(resp_result), 64'h0);
`ifdef SUMADOR_ARB_CARRY_EN
    check("wrap_carry", 64'(resp_carry), 64'h1);
`endif
    check("sole_regrant", 64'(req_ready), 64'h8);
    push_grant(3);
    step();
    req_valid = 4'b0000;
    @(negedge clk);
    check("small_result", 64'(resp_result), 64'd7);
`ifdef SUMADOR_ARB_CARRY_EN
    check("small_carry", 64'(resp_carry), 64'h0);
`endif
    step();

    // Move ptr to 3 by granting requester 2
    opa[2] = 32'd1; opb[2] = 32'd2;
    req_valid = 4'b0100;
    @(negedge clk);
    check("pre_rst_grant", 64'(req_ready), 64'h4);
    push_grant(2);
    step();

    // Mid-operation reset while a result is held
    req_valid  = 4'b1100;
    resp_ready = 1'b0;
    #1;
    check("pre_rst_valid", 64'(resp_valid), 64'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(resp_valid), 64'h0);
    check("mid_rst_result", 64'(resp_result), 64'h0);
    check("mid_rst_no_grant", 64'(req_ready), 64'h0);
    sb.delete();
    #1;
    rst_n      = 1'b1;
    resp_ready = 1'b1;
    opa[2] = 32'd40; opb[2] = 32'd2;
    @(negedge clk);
    check("post_rst_grant", 64'(req_ready), 64'h4);
    push_grant(2);
    step();
    req_valid = 4'b0000;
    @(negedge clk);
    check("post_rst_result", 64'(resp_result), 64'd42);
    step();
    step();

    check("sb_drained", 64'(sb.size()), 64'h0);
    check("idle_valid", 64'(resp_valid), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/arbitro_sumador.md
# arbitro_sumador

Shares a single DATA_W-bit adder between NUM_REQ requesters in the datapath, such as PC increment, branch-target and address-offset units. Each requester posts an operand pair with a valid/ready handshake. A round-robin arbiter picks one pair per cycle, and the sum is returned through one registered, back-pressurable response port tagged with the requester ID. The block sits between the requesting pipeline units and the shared 32-bit adder.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- DATA_W, 32: operand and result width.
- ID_W, $clog2(NUM_REQ): derived, not overridable.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  requester i has an operand pair posted.
- req_a  in  NUM_REQ*DATA_W  flattened operand A; requester i occupies bits [i*DATA_W +: DATA_W].
- req_b  in  NUM_REQ*DATA_W  flattened operand B, same packing as req_a.
- req_ready  out  NUM_REQ  one-hot grant; requester i transfers when req_valid[i] & req_ready[i].
- resp_valid  out  1  a result is held in the output register.
- resp_id  out  ID_W  index of the requester that owns the result.
- resp_result  out  DATA_W  a + b modulo 2^DATA_W.
- resp_ready  in  1  consumer accepts the result.
- resp_carry  out  1  carry-out of the sum; present only with SUMADOR_ARB_CARRY_EN.
- busy  out  1  equals resp_valid.

## Operation
- FSM has two states, EMPTY and FULL, tracked by resp_valid.
- can_accept = !resp_valid | resp_ready.
- A grant is issued only when can_accept is high and at least one req_valid bit is set.
- Winner selection is round-robin:
  - Search starts at index ptr and wraps modulo NUM_REQ.
  - The first set req_valid bit wins.
  - After a grant, ptr becomes winner+1 mod NUM_REQ. Otherwise ptr holds.
- State transitions:
  - EMPTY → FULL on a grant.
  - FULL → FULL on a grant while resp_ready is high; the output is overwritten in the same edge.
  - FULL → EMPTY when resp_ready is high and there is no grant.
  - FULL holds when resp_ready is low.
- Requesters hold req_valid and operands stable until granted. The block never latches an ungranted pair.
- Deasserting req_valid before a grant is legal and costs nothing.
- The sum is unsigned modulo 2^DATA_W and wraps. The carry is discarded unless the macro is defined.
- While FULL and resp_ready is low, resp_id, resp_result and resp_carry stay stable every cycle.
- A requester may be granted again on consecutive cycles only if it is the sole requester.
- Reset values, all asynchronous: resp_valid 0, resp_id 0, resp_result 0, resp_carry 0, ptr 0, state EMPTY.
- Reset asserted mid-operation discards the held result immediately. No grant is issued while rst_n is low.

## Timing
- req_ready is combinational from req_valid, ptr, resp_valid and resp_ready. There is no path from req_a or req_b to req_ready.
- Latency is 1 cycle: a pair granted at edge N has resp_valid high after edge N.
- Throughput is 1 result per cycle while resp_ready stays high.
- A result is consumed at the edge where resp_valid and resp_ready are both high.
- The adder path is req mux → adder → output register, within one cycle.

## Configuration
- SUMADOR_ARB_CARRY_EN defined:
  - The resp_carry port exists.
  - The adder is DATA_W+1 bits wide and the MSB is registered as resp_carry.
- SUMADOR_ARB_CARRY_EN undefined:
  - The port is absent.
  - The adder is DATA_W bits wide and there is no carry register.

## Structure
- Shared package holds:
  - the state encoding (ST_EMPTY, ST_FULL);
  - default constants NUM_REQ_DEF = 4 and DATA_W_DEF = 32;
  - a function for the round-robin index increment.
- One sub-module, arb_rr_pick, is natural:
  - pure combinational priority search;
  - inputs: req vector, ptr, enable;
  - outputs: one-hot grant, winner index, any.
- The output register, ptr and the adder live in arbitro_sumador.

## Test plan
- Reset: hold rst_n low with every req_valid high → req_ready = 0, resp_valid = 0, resp_result = 0. After release, the first grant goes to index 0.
- Single request: req 1 with a = 5, b = 7, resp_ready = 1 → req_ready = 4'b0010. Next cycle resp_valid = 1, resp_id = 1, resp_result = 12.
- Fairness: req_valid = 4'b1111 for 5 cycles with resp_ready = 1 → grant order 0, 1, 2, 3, 0 and one result per cycle, each carrying the matching ID.
- Backpressure: resp_valid = 1, resp_ready = 0, req 2 pending → req_ready = 0 for 3 cycles with the output stable. When resp_ready rises, req 2 is granted in that cycle and its result replaces the old one on the next edge.
- Wrap: a = 32'hFFFFFFFF, b = 1 → resp_result = 0; with SUMADOR_ARB_CARRY_EN, resp_carry = 1. Then a = 3, b = 4 → resp_result = 7 and resp_carry = 0.
- Mid-operation reset: pulse rst_n low between clock edges while resp_valid = 1 → resp_valid drops immediately and ptr returns to 0. Afterwards, req_valid = 4'b1100 is granted to index 2 first.
